// File: rtl/lane_obstacle_engine.sv
// -----------------------------------------------------------------------------
// lane_obstacle_engine
//
// Holds NUM_LANES horizontally scrolling obstacles, one per lane, each moving
// with its own direction and a shared selectable speed. All horizontal
// arithmetic wraps modulo SCREEN_W, so an obstacle that crosses the right edge
// is drawn split across both edges. Produces a registered obstacle pixel for
// the colour stage and a registered player-collision flag with a sticky hit.
//
// Ports:
//   clk         in   pixel clock
//   reset       in   synchronous, active-high reset
//   tick        in   one-cycle move strobe
//   enable      in   motion enable
//   speed       in   [1:0] speed level, step = STEP*(speed+1)
//   CounterX    in   [9:0] current pixel column
//   CounterY    in   [9:0] current pixel row
//   player_x    in   [9:0] player left edge
//   player_y    in   [9:0] player top edge
//   clear_hit   in   clears the sticky hit when no collision is present
//   obstacle_on out  current pixel (one cycle ago) lies on an obstacle
//   collision   out  player overlapped some obstacle (one cycle ago)
//   hit         out  sticky collision flag
//   hit_lane    out  [2:0] lowest-index lane that set hit
// -----------------------------------------------------------------------------
module lane_obstacle_engine #(
    parameter int NUM_LANES     = 6,
    parameter int LANE_Y0       = 60,
    parameter int LANE_H        = 60,
    parameter int SCREEN_W      = 640,
    parameter int OBST_W        = 20,
    parameter int SPACING       = 120,
    parameter int STEP          = 10,
    parameter int PLAYER_W      = 60,
    parameter int PLAYER_H      = 60,
    parameter int ALT_DIR       = 1,
    parameter int FREEZE_ON_HIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       clear_hit,
    output logic       obstacle_on,
    output logic       collision,
    output logic       hit,
    output logic [2:0] hit_lane
);

    // Reset position of lane k.
    function automatic logic [9:0] init_pos(input int k);
        return 10'((k * SPACING) % SCREEN_W);
    endfunction

    // (a - b) mod SCREEN_W for any 10-bit a, b; a may lie beyond the visible
    // width (blanking columns, off-screen player), so up to two corrections
    // in each direction are needed.
    function automatic logic [9:0] mod_sub(input logic [9:0] a, input logic [9:0] b);
        logic signed [12:0] t;
        logic signed [12:0] w;
        w = 13'(SCREEN_W);
        t = $signed({3'b000, a}) - $signed({3'b000, b});
        t = (t < 13'sd0) ? (t + w) : t;
        t = (t < 13'sd0) ? (t + w) : t;
        t = (t >= w) ? (t - w) : t;
        t = (t >= w) ? (t - w) : t;
        return t[9:0];
    endfunction

    logic [9:0]           pos_q [NUM_LANES];
    logic [9:0]           pos_d [NUM_LANES];
    logic                 obstacle_on_q, obstacle_on_d;
    logic                 collision_q, collision_d;
    logic                 hit_q, hit_d;
    logic [2:0]           hit_lane_q, hit_lane_d;

    logic [10:0]          step_s;
    logic                 move_s;
    logic [10:0]          sum_s;
    logic [11:0]          top_s;
    logic [11:0]          bot_s;
    logic [NUM_LANES-1:0] lane_pix_s;
    logic [NUM_LANES-1:0] lane_col_s;
    logic [2:0]           first_lane_s;

    // Next positions: wrap-around move of every lane when motion is allowed.
    always_comb begin
        step_s = 11'(STEP) * (11'(speed) + 11'd1);
        move_s = tick && enable && !((FREEZE_ON_HIT != 0) && hit_q);
        sum_s  = 11'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
            pos_d[k] = pos_q[k];
            if (move_s) begin
                if ((ALT_DIR != 0) && ((k % 2) == 1)) begin
                    if ({1'b0, pos_q[k]} >= step_s) begin
                        pos_d[k] = 10'({1'b0, pos_q[k]} - step_s);
                    end else begin
                        pos_d[k] = 10'({1'b0, pos_q[k]} + 11'(SCREEN_W) - step_s);
                    end
                end else begin
                    sum_s = {1'b0, pos_q[k]} + step_s;
                    if (sum_s >= 11'(SCREEN_W)) begin
                        pos_d[k] = 10'(sum_s - 11'(SCREEN_W));
                    end else begin
                        pos_d[k] = 10'(sum_s);
                    end
                end
            end else begin
                pos_d[k] = pos_q[k];
            end
        end
    end

    // Per-lane pixel and player-overlap terms, lowest colliding lane.
    always_comb begin
        lane_pix_s   = '0;
        lane_col_s   = '0;
        first_lane_s = 3'd0;
        top_s        = 12'd0;
        bot_s        = 12'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
            top_s = 12'(LANE_Y0 + k * LANE_H);
            bot_s = 12'(LANE_Y0 + (k + 1) * LANE_H);
            lane_pix_s[k] = ({2'b00, CounterY} >= top_s) && ({2'b00, CounterY} < bot_s)
                          && ({1'b0, CounterX} < 11'(SCREEN_W))
                          && ({1'b0, mod_sub(CounterX, pos_q[k])} < 11'(OBST_W));
            lane_col_s[k] = ({2'b00, player_y} < bot_s)
                          && (({2'b00, player_y} + 12'(PLAYER_H)) > top_s)
                          && (({1'b0, mod_sub(player_x, pos_q[k])} < 11'(OBST_W))
                              || ({1'b0, mod_sub(pos_q[k], player_x)} < 11'(PLAYER_W)));
        end
        // Scan downwards so the lowest colliding index is the last one written.
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (lane_col_s[k]) begin
                first_lane_s = 3'(k);
            end else begin
                first_lane_s = first_lane_s;
            end
        end
    end

    // Output next-state: pixel, collision, sticky hit (set beats clear).
    always_comb begin
        obstacle_on_d = |lane_pix_s;
        collision_d   = |lane_col_s;
        hit_d         = hit_q;
        hit_lane_d    = hit_lane_q;
        if (collision_d) begin
            hit_d = 1'b1;
            if (!hit_q) begin
                hit_lane_d = first_lane_s;
            end else begin
                hit_lane_d = hit_lane_q;
            end
        end else if (clear_hit) begin
            hit_d = 1'b0;
        end else begin
            hit_d = hit_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                pos_q[k] <= init_pos(k);
            end
            obstacle_on_q <= 1'b0;
            collision_q   <= 1'b0;
            hit_q         <= 1'b0;
            hit_lane_q    <= 3'd0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                pos_q[k] <= pos_d[k];
            end
            obstacle_on_q <= obstacle_on_d;
            collision_q   <= collision_d;
            hit_q         <= hit_d;
            hit_lane_q    <= hit_lane_d;
        end
    end

    assign obstacle_on = obstacle_on_q;
    assign collision   = collision_q;
    assign hit         = hit_q;
    assign hit_lane    = hit_lane_q;

endmodule

// File: tb/tb_lane_obstacle_engine.sv
// -----------------------------------------------------------------------------
// tb_lane_obstacle_engine
//
// Drives directed scenarios followed by random traffic and compares every
// registered output against a behavioural model built from integer modulo
// arithmetic on an array of obstacle positions.
// -----------------------------------------------------------------------------
module tb_lane_obstacle_engine;

    localparam int NL  = 6;
    localparam int Y0  = 60;
    localparam int LH  = 60;
    localparam int W   = 640;
    localparam int OW  = 20;
    localparam int SP  = 120;
    localparam int ST  = 10;
    localparam int PW  = 60;
    localparam int PH  = 60;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       enable;
    logic [1:0] speed;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       clear_hit;
    logic       obstacle_on;
    logic       collision;
    logic       hit;
    logic [2:0] hit_lane;

    int checks_cnt = 0;
    int errors_cnt = 0;

    int mpos [NL];
    int mhit;
    int mlane;

    lane_obstacle_engine dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .enable     (enable),
        .speed      (speed),
        .CounterX   (CounterX),
        .CounterY   (CounterY),
        .player_x   (player_x),
        .player_y   (player_y),
        .clear_hit  (clear_hit),
        .obstacle_on(obstacle_on),
        .collision  (collision),
        .hit        (hit),
        .hit_lane   (hit_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int md(input int v);
        return ((v % W) + W) % W;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict from current inputs and model, clock, then compare.
    task automatic cycle();
        int e_on;
        int e_col;
        int e_hit;
        int e_lane;
        int first;
        int s;
        int top;
        int bot;
        int moving;
        int npos [NL];
        e_on = 0; e_col = 0; first = -1;
        if (reset) begin
            for (int k = 0; k < NL; k++) npos[k] = (k * SP) % W;
            e_hit = 0;
            e_lane = 0;
        end else begin
            s = ST * (int'(speed) + 1);
            for (int k = 0; k < NL; k++) begin
                top = Y0 + k * LH;
                bot = top + LH;
                if (int'(CounterY) >= top && int'(CounterY) < bot && int'(CounterX) < W
                    && md(int'(CounterX) - mpos[k]) < OW)
                    e_on = 1;
                if (int'(player_y) < bot && int'(player_y) + PH > top
                    && (md(int'(player_x) - mpos[k]) < OW || md(mpos[k] - int'(player_x)) < PW)) begin
                    e_col = 1;
                    if (first < 0) first = k;
                end
            end
            e_hit  = e_col ? 1 : (clear_hit ? 0 : mhit);
            e_lane = (e_col && mhit == 0) ? first : mlane;
            moving = (tick && enable && mhit == 0) ? 1 : 0;
            for (int k = 0; k < NL; k++) begin
                if (moving == 0)      npos[k] = mpos[k];
                else if (k % 2 == 1)  npos[k] = md(mpos[k] - s);
                else                  npos[k] = md(mpos[k] + s);
            end
        end
        @(posedge clk);
        #1;
        check_eq("obstacle_on", int'(obstacle_on), e_on);
        check_eq("collision", int'(collision), e_col);
        check_eq("hit", int'(hit), e_hit);
        check_eq("hit_lane", int'(hit_lane), e_lane);
        for (int k = 0; k < NL; k++) mpos[k] = npos[k];
        mhit  = e_hit;
        mlane = e_lane;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; tick = 1'b0; enable = 1'b1; speed = 2'd0;
        CounterX = 10'd0; CounterY = 10'd0;
        player_x = 10'd0; player_y = 10'd1000; clear_hit = 1'b0;
    endtask

    initial begin
        idle_inputs();
        mhit = 0; mlane = 0;
        for (int k = 0; k < NL; k++) mpos[k] = 0;

        // Reset and outputs all zero afterwards.
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // 63 ticks at speed 0: lane 0 reaches 630, lane 5 wraps leftwards.
        for (int i = 0; i < 63; i++) begin
            tick = 1'b1;
            CounterX = 10'($urandom_range(0, 1023));
            CounterY = 10'($urandom_range(0, 479));
            cycle();
            tick = 1'b0;
            cycle();
        end

        // Split obstacle at the right edge in lane 0.
        CounterY = 10'd60;
        CounterX = 10'd635; cycle();
        CounterX = 10'd9;   cycle();
        CounterX = 10'd10;  cycle();
        CounterX = 10'd639; cycle();
        CounterX = 10'd640; cycle();

        // speed=3 tick from 630 wraps to 30.
        speed = 2'd3; tick = 1'b1; cycle();
        tick = 1'b0; speed = 2'd0;
        CounterX = 10'd30; cycle();
        CounterX = 10'd49; cycle();
        CounterX = 10'd50; cycle();

        // Player overlapping lane 0 from the left: hit, then clear while overlapping.
        player_y = 10'd60;
        player_x = 10'(md(mpos[0] - 50));
        cycle();
        clear_hit = 1'b1; cycle();
        clear_hit = 1'b0;
        // Frozen: ticks do not move anything.
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
        // Move away, clear, then ticks move lanes again.
        player_y = 10'd1000; cycle();
        clear_hit = 1'b1; cycle();
        clear_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; CounterY = 10'd60; CounterX = 10'(mpos[0]); cycle();
            tick = 1'b0; cycle();
        end

        // enable=0: ticks ignored and not queued.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
        enable = 1'b1; cycle();
        CounterY = 10'd60; CounterX = 10'(mpos[0]); cycle();

        // Reset during a tick cycle restores the initial positions.
        tick = 1'b1; reset = 1'b1; cycle();
        tick = 1'b0; reset = 1'b0;
        CounterY = 10'd60; CounterX = 10'd5; cycle();
        CounterY = 10'd120; CounterX = 10'd125; cycle();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 499) == 0);
            tick      = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            speed     = 2'($urandom_range(0, 3));
            CounterX  = 10'($urandom_range(0, 1023));
            CounterY  = 10'($urandom_range(0, 480));
            clear_hit = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                player_x = 10'($urandom_range(0, 1023));
                player_y = 10'($urandom_range(0, 700));
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
